reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of each register.
REQ-002 SHALL have parameter NREG, default 32, number of registers; power of two, at least 4.
REQ-003 SHALL have parameter AW, default 5, address width; equals log2(NREG).
REQ-004 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port we, input, 1, write enable.
REQ-007 SHALL have port waddr, input, AW, write address.
REQ-008 SHALL have port wdata, input, XLEN, write data.
REQ-009 SHALL have port re, input, 1, read enable for both read ports.
REQ-010 SHALL have ports ra1 and ra2, input, AW each, read addresses.
REQ-011 SHALL have ports rd1 and rd2, output, XLEN each, registered read data.
REQ-012 SHALL have port rvalid, output, 1, rd1/rd2 valid for the current cycle.
REQ-013 SHALL have port clr, input, 1, request to zero the whole file.
REQ-014 SHALL have port busy, output, 1, high while a clear sweep is in progress.

Function
REQ-015 Register 0 SHALL always read as zero; writes to address 0 SHALL be discarded.
REQ-016 In IDLE, at a rising edge with we=1 and waddr!=0, reg[waddr] SHALL take wdata.
REQ-017 In IDLE, at a rising edge with re=1, rd1/rd2 SHALL load the contents of reg[ra1]/reg[ra2], and rvalid SHALL be 1 in the following cycle. Read latency is 1 cycle.
REQ-018 A read in the same cycle as a write to the same nonzero address SHALL bypass: the read port SHALL load wdata, not the old contents.
REQ-019 Bypass SHALL apply to each port independently; ra1==ra2==waddr SHALL give wdata on both ports.
REQ-020 A rising edge with re=0 SHALL clear rvalid to 0; rd1/rd2 SHALL keep their previous values.
REQ-021 The FSM SHALL have two states, IDLE and CLEAR; busy=1 exactly when the state is CLEAR.
REQ-022 IDLE->CLEAR SHALL occur at a rising edge with clr=1, and the sweep index SHALL load 1.
REQ-023 In CLEAR, each rising edge SHALL zero reg[index] and increment index.
REQ-024 When index==NREG-1 is zeroed, the FSM SHALL return to IDLE; busy SHALL therefore last exactly NREG-1 cycles.
REQ-025 In CLEAR, we and re SHALL be ignored; rvalid SHALL be 0 and rd1/rd2 SHALL hold.
REQ-026 clr asserted while busy=1 SHALL be ignored; the sweep SHALL NOT restart.
REQ-027 clr and we in the same IDLE cycle: clr SHALL win, and the write SHALL be discarded.
REQ-028 clr and re in the same IDLE cycle: the read SHALL complete per REQ-017/018, and the sweep SHALL start in the same edge.
REQ-029 Read addresses SHALL be unsigned; all AW-bit values below NREG are legal, with no wrap logic required.

Reset
REQ-030 rst=1 SHALL, without waiting for clk, set all registers, rd1, rd2, rvalid and busy to 0, set the FSM to IDLE and set index to 0.
REQ-031 rst asserted mid-sweep SHALL abort the sweep. After release the FSM SHALL be IDLE, and the first rising edge after release SHALL obey REQ-016..028.
REQ-032 While rst=1, no write SHALL take effect.

Verification
REQ-033 Write reg5=0xDEADBEEF, next cycle re=1 ra1=5 ra2=0 -> one cycle later rd1=0xDEADBEEF, rd2=0, rvalid=1.
REQ-034 Same cycle: we=1 waddr=7 wdata=0x12345678, re=1 ra1=7 ra2=7 -> next cycle rd1=rd2=0x12345678; a later read of reg7 returns the same value.
REQ-035 Write 0xFFFFFFFF to address 0, then read ra1=0 -> rd1=0.
REQ-036 Fill reg1..reg31 with nonzero values, pulse clr -> busy=1 for exactly 31 cycles, and re/we during that time have no effect. After busy falls, reading regs 1..31 gives 0.
REQ-037 Assert rst asynchronously between clock edges at sweep index 10 -> busy, rvalid, rd1, rd2 become 0 immediately; after release, reads of previously written registers give 0.
REQ-038 Pulse clr a second time at index 20 -> busy still falls after 31 cycles in total, with no restart.

Source files
------------

// File: rtl/reg_file.sv
// rtl/reg_file.sv - two-read one-write register file with write bypass and a sweeping clear
module reg_file #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic            re,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            rvalid,
    input  logic            clr,
    output logic            busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    logic [AW-1:0]     r_idx;
    logic [XLEN-1:0]   r_regs [NREG];

    logic              w_wr;
    logic [XLEN-1:0]   w_rd1;
    logic [XLEN-1:0]   w_rd2;

    // A write that loses to clr never happens, so it is never bypassed either.
    assign w_wr  = we && (waddr != '0) && !clr;
    assign w_rd1 = (w_wr && (ra1 == waddr)) ? wdata : r_regs[ra1];
    assign w_rd2 = (w_wr && (ra2 == waddr)) ? wdata : r_regs[ra2];

    assign busy = (r_state == CLEAR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            rd1     <= '0;
            rd2     <= '0;
            rvalid  <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (re) begin
                        rd1    <= w_rd1;
                        rd2    <= w_rd2;
                        rvalid <= 1'b1;
                    end else begin
                        rvalid <= 1'b0;
                    end
                    if (w_wr) begin
                        r_regs[waddr] <= wdata;
                    end
                    if (clr) begin
                        r_state <= CLEAR;
                        r_idx   <= AW'(1);
                    end
                end
                CLEAR: begin
                    rvalid       <= 1'b0;
                    r_regs[r_idx] <= '0;
                    if (r_idx == AW'(NREG - 1)) begin
                        r_state <= IDLE;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + AW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed vector and sequence bench for reg_file
module tb_reg_file;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk;
    logic            rst;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic            re;
    logic [AW-1:0]   ra1;
    logic [AW-1:0]   ra2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            rvalid;
    logic            clr;
    logic            busy;

    reg_file #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re     (re),
        .ra1    (ra1),
        .ra2    (ra2),
        .rd1    (rd1),
        .rd2    (rd2),
        .rvalid (rvalid),
        .clr    (clr),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            we;
        logic [AW-1:0]   waddr;
        logic [XLEN-1:0] wdata;
        logic            re;
        logic [AW-1:0]   ra1;
        logic [AW-1:0]   ra2;
        logic [XLEN-1:0] e_rd1;
        logic [XLEN-1:0] e_rd2;
        logic            e_rvalid;
    } vec_t;

    vec_t vecs [11];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic drive(input logic i_we, input logic [AW-1:0] i_wa, input logic [XLEN-1:0] i_wd,
                         input logic i_re, input logic [AW-1:0] i_r1, input logic [AW-1:0] i_r2,
                         input logic i_clr);
        we = i_we; waddr = i_wa; wdata = i_wd; re = i_re; ra1 = i_r1; ra2 = i_r2; clr = i_clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          cnt;
    int          guard;
    logic        bad;
    logic [31:0] hold1;

    initial begin
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b1};
        vecs[2]  = '{1'b1, 5'd7,  32'h12345678, 1'b1, 5'd7,  5'd7,  32'h12345678, 32'h12345678, 1'b1};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd5,  32'h12345678, 32'hDEADBEEF, 1'b1};
        vecs[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  5'd0,  32'h12345678, 32'hDEADBEEF, 1'b0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd7,  32'h0,        32'h12345678, 1'b1};
        vecs[6]  = '{1'b1, 5'd3,  32'h0A0A0A0A, 1'b1, 5'd3,  5'd5,  32'h0A0A0A0A, 32'hDEADBEEF, 1'b1};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd3,  5'd3,  32'h0A0A0A0A, 32'hDEADBEEF, 1'b0};
        vecs[8]  = '{1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 5'd2,  5'd31, 32'h0,        32'hCAFEF00D, 1'b1};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 5'd3,  32'hCAFEF00D, 32'h0A0A0A0A, 1'b1};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd6,  5'd0,  32'h0,        32'h0,        1'b1};

        // Reset with a write attempt held on the bus; reg6 must stay zero.
        rst = 1'b1;
        drive(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 5'd0, 1'b0);
        #1;
        check("reset_rd1", rd1, 32'h0);
        check("reset_rd2", rd2, 32'h0);
        check("reset_rvalid", {31'h0, rvalid}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        tick(); tick();
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0);
        tick();

        for (int v = 0; v < 11; v++) begin
            drive(vecs[v].we, vecs[v].waddr, vecs[v].wdata, vecs[v].re, vecs[v].ra1, vecs[v].ra2, 1'b0);
            tick();
            check($sformatf("vec%0d_rd1", v), rd1, vecs[v].e_rd1);
            check($sformatf("vec%0d_rd2", v), rd2, vecs[v].e_rd2);
            check($sformatf("vec%0d_rvalid", v), {31'h0, rvalid}, {31'h0, vecs[v].e_rvalid});
            check($sformatf("vec%0d_busy", v), {31'h0, busy}, 32'h0);
        end

        // Full clear: fill, clear alongside a read, ignore traffic while busy.
        for (int i = 1; i < NREG; i++) begin
            drive(1'b1, AW'(i), 32'h1000_0000 | i, 1'b0, 5'd0, 5'd0, 1'b0);
            tick();
        end
        drive(1'b1, 5'd9, 32'hBAD0BAD0, 1'b1, 5'd1, 5'd2, 1'b1);
        tick();
        check("clr_read_rd1", rd1, 32'h1000_0001);
        check("clr_read_rd2", rd2, 32'h1000_0002);
        check("clr_read_rvalid", {31'h0, rvalid}, 32'h1);
        check("clr_busy", {31'h0, busy}, 32'h1);
        cnt = 1; guard = 0; bad = 1'b0;
        while (busy && guard < 100) begin
            drive(1'b1, 5'd4, 32'h55, 1'b1, 5'd4, 5'd4, 1'b0);
            tick();
            guard++;
            if (busy) cnt++;
            if (rvalid !== 1'b0 || rd1 !== 32'h1000_0001 || rd2 !== 32'h1000_0002) bad = 1'b1;
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0);
        check("clr_busy_cycles", cnt, 32'd31);
        check("clr_ignored_reads", {31'h0, bad}, 32'h0);
        for (int i = 1; i < NREG; i++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, AW'(i), AW'(NREG - i), 1'b0);
            tick();
            check($sformatf("cleared_reg%0d", i), rd1 | rd2, 32'h0);
        end

        // Asynchronous reset in the middle of a sweep at index 10.
        drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 5'd0, 1'b0);
        tick();
        drive(1'b1, 5'd12, 32'h1212, 1'b0, 5'd0, 5'd0, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd12, 1'b1);
        tick();
        check("abort_pre_rd1", rd1, 32'h99);
        check("abort_pre_rd2", rd2, 32'h1212);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0);
        cnt = 1; guard = 0;
        while (cnt < 10 && guard < 100) begin
            tick();
            guard++;
            if (busy) cnt++;
        end
        check("abort_reached_idx10", cnt, 32'd10);
        check("abort_busy_before", {31'h0, busy}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_rvalid", {31'h0, rvalid}, 32'h0);
        check("abort_rd1", rd1, 32'h0);
        check("abort_rd2", rd2, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 5'd9, 1'b0);
        tick();
        check("abort_after_rd1", rd1, 32'h0);
        check("abort_after_rd2", rd2, 32'h0);
        check("abort_after_rvalid", {31'h0, rvalid}, 32'h1);
        check("abort_after_busy", {31'h0, busy}, 32'h0);

        // clr raised again at index 20 must not restart the sweep.
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1);
        tick();
        cnt = 1; guard = 0;
        while (busy && guard < 100) begin
            drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, (cnt == 20));
            tick();
            guard++;
            if (busy) cnt++;
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0);
        check("reclr_busy_cycles", cnt, 32'd31);

        // Back in IDLE, normal write and read work again.
        drive(1'b1, 5'd20, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd0, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 5'd1, 1'b0);
        tick();
        check("post_rd1", rd1, 32'hA5A5A5A5);
        check("post_rd2", rd2, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
